mem_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction cache request path (iREN/iaddr) and the data cache request path (dREN/dWEN/daddr/dstore). It sits between the caches and the RAM model. Data accesses have priority. A bounded starvation counter guarantees forward progress for instruction fetches. Each grant is held until RAM reports ACCESS, and stall signals return to the caches so the pipeline stall logic can freeze stages.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D caches, the RAM model and mem_arbiter.
// The arbiter takes the slave view; the environment (caches + RAM) takes the master view.
interface mem_arbiter_if;
    // Instruction cache side
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    // Data cache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ramerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the instruction and data caches.
// Data has priority; a saturating starvation counter forces an instruction
// grant after STARVE_MAX consecutive data grants with a fetch pending.
// Each grant is held until RAM reports ACCESS, then one IDLE arbitration cycle follows.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFETCH = 2'd1;
    localparam logic [1:0] DREAD  = 2'd2;
    localparam logic [1:0] DWRITE = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_count;
    logic [3:0] w_next_count;
    logic [3:0] w_data_count;
    logic       r_ramerr;
    logic       w_own_req;
    logic       w_serving;
    logic       w_done;

    // Is the request that owns the current service state still asserted?
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_own_req = 1'b0;
        case (r_state)
            IFETCH:  w_own_req = bus.iREN;
            DREAD:   w_own_req = bus.dREN;
            DWRITE:  w_own_req = bus.dWEN;
            default: w_own_req = 1'b0;
        endcase
    end

    // A withdrawn request drops out of service immediately (abort); ACCESS completes it.
    assign w_serving = (r_state != IDLE) && w_own_req;
    assign w_done    = w_serving && (bus.ramstate == RAM_ACCESS);

    // Counter value after a data grant: count skips only while a fetch is waiting.
    assign w_data_count = !bus.iREN ? 4'd0 :
                          (r_count >= C_STARVE_MAX) ? C_STARVE_MAX : r_count + 4'd1;

    // Arbitration in IDLE and service-state exit conditions.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (bus.iREN && (r_count == C_STARVE_MAX)) begin
                    w_next_state = IFETCH;
                    w_next_count = 4'd0;
                end else if (bus.dWEN) begin
                    w_next_state = DWRITE;
                    w_next_count = w_data_count;
                end else if (bus.dREN) begin
                    w_next_state = DREAD;
                    w_next_count = w_data_count;
                end else if (bus.iREN) begin
                    w_next_state = IFETCH;
                    w_next_count = 4'd0;
                end
            end
            default: begin
                // ERROR and BUSY/FREE both hold the state so the access retries or waits.
                if (!w_own_req || w_done) begin
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    // State, starvation counter and sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_ramerr <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_serving && (bus.ramstate == RAM_ERROR)) begin
                r_ramerr <= 1'b1;
            end
        end
    end

    // RAM port drive: zero unless a live request is in service.
    assign bus.ramREN   = w_serving && ((r_state == IFETCH) || (r_state == DREAD));
    assign bus.ramWEN   = w_serving && (r_state == DWRITE);
    assign bus.ramaddr  = !w_serving         ? 32'd0 :
                          (r_state == IFETCH) ? bus.iaddr : bus.daddr;
    assign bus.ramstore = (w_serving && (r_state == DWRITE)) ? bus.dstore : 32'd0;

    // Stalls drop only on the completing cycle of the owning master.
    assign bus.iwait  = !(w_done && (r_state == IFETCH));
    assign bus.dwait  = !(w_done && (r_state != IFETCH));
    assign bus.iload  = bus.ramload;
    assign bus.dload  = bus.ramload;
    assign bus.ramerr = r_ramerr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic inputs_idle();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'd0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        bus.ramload  = 32'd0;
        bus.ramstate = S_FREE;
    endtask

    // Reference model state (transaction level)
    int   m_owner;   // 0 none, 1 fetch, 2 data read, 3 data write
    int   m_skips;   // data grants made while a fetch was pending
    bit   m_err;
    bit   i_act, d_act, i_done, d_done, active;
    int   d_kind;    // 0 read, 1 write, 2 read+write
    int   r;
    logic e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    string grants;

    initial begin
        inputs_idle();
        rst = 1'b1;
        #12;
        // Reset state
        check("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_ramstore", bus.ramstore, 32'd0);
        check("rst_iwait", 32'(bus.iwait), 32'd1);
        check("rst_dwait", 32'(bus.dwait), 32'd1);
        check("rst_ramerr", 32'(bus.ramerr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch, ACCESS on first service cycle
        @(negedge clk);
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        #1 check("fetch_idle_iwait", 32'(bus.iwait), 32'd1);
        @(negedge clk);
        bus.ramstate = S_ACCESS; bus.ramload = 32'h8C010004;
        #1;
        check("fetch_ramREN", 32'(bus.ramREN), 32'd1);
        check("fetch_ramaddr", bus.ramaddr, 32'h40);
        check("fetch_iwait", 32'(bus.iwait), 32'd0);
        check("fetch_iload", bus.iload, 32'h8C010004);
        check("fetch_dwait", 32'(bus.dwait), 32'd1);
        @(negedge clk);
        bus.iREN = 1'b0; bus.ramstate = S_FREE;
        #1 check("fetch_after_ramREN", 32'(bus.ramREN), 32'd0);

        // Write with 3 BUSY cycles then ACCESS
        @(negedge clk);
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        #1 check("wr_idle_dwait", 32'(bus.dwait), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.ramstate = (k < 3) ? S_BUSY : S_ACCESS;
            #1;
            check("wr_ramWEN", 32'(bus.ramWEN), 32'd1);
            check("wr_ramaddr", bus.ramaddr, 32'h100);
            check("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
            check("wr_dwait", 32'(bus.dwait), (k < 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.dWEN = 1'b0; bus.ramstate = S_FREE;
        #1 check("wr_after_ramWEN", 32'(bus.ramWEN), 32'd0);

        // Fairness: iREN and dREN held, ACCESS every cycle
        grants = "";
        @(negedge clk);
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        bus.ramstate = S_ACCESS;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.ramREN) begin
                if (bus.ramaddr == 32'h200) begin
                    grants = {grants, "I"};
                    check("fair_count_after_I", 32'(dut.r_count), 32'd0);
                end else begin
                    grants = {grants, "D"};
                end
            end
        end
        n_checks++;
        assert (grants == "DDDDIDDDDI") else begin
            n_err++;
            $error("FAIL fair_order: observed=%s expected=DDDDIDDDDI", grants);
        end
        @(negedge clk);
        inputs_idle();

        // Abort of a fetch during BUSY
        @(negedge clk);
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = S_BUSY;
        @(negedge clk);
        #1 check("abort_busy_ramREN", 32'(bus.ramREN), 32'd1);
        @(negedge clk);
        bus.iREN = 1'b0;
        #1;
        check("abort_ramREN", 32'(bus.ramREN), 32'd0);
        check("abort_iwait", 32'(bus.iwait), 32'd1);
        @(negedge clk);
        #1;
        check("abort_state_idle", 32'(dut.r_state), 32'd0);
        check("abort_after_ramREN", 32'(bus.ramREN), 32'd0);
        inputs_idle();

        // Error retry on a data read
        @(negedge clk);
        bus.dREN = 1'b1; bus.daddr = 32'h44;
        @(negedge clk);
        bus.ramstate = S_ERROR;
        #1;
        check("err_ramREN", 32'(bus.ramREN), 32'd1);
        check("err_dwait", 32'(bus.dwait), 32'd1);
        @(negedge clk);
        bus.ramstate = S_ACCESS; bus.ramload = 32'h12345678;
        #1;
        check("err_ramerr", 32'(bus.ramerr), 32'd1);
        check("err_retry_ramREN", 32'(bus.ramREN), 32'd1);
        check("err_retry_dwait", 32'(bus.dwait), 32'd0);
        check("err_dload", bus.dload, 32'h12345678);
        @(negedge clk);
        bus.dREN = 1'b0; bus.ramstate = S_FREE;
        #1 check("err_sticky", 32'(bus.ramerr), 32'd1);

        // Reset mid-write (count made nonzero by a pending fetch)
        @(negedge clk);
        bus.dWEN = 1'b1; bus.daddr = 32'h10; bus.dstore = 32'hCAFEF00D; bus.iREN = 1'b1;
        @(negedge clk);
        bus.ramstate = S_BUSY;
        #1 check("rstw_ramWEN_before", 32'(bus.ramWEN), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstw_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rstw_dwait", 32'(bus.dwait), 32'd1);
        check("rstw_ramstore", bus.ramstore, 32'd0);
        check("rstw_state", 32'(dut.r_state), 32'd0);
        check("rstw_count", 32'(dut.r_count), 32'd0);
        check("rstw_ramerr", 32'(bus.ramerr), 32'd0);
        inputs_idle();
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the reference model
        m_owner = 0; m_skips = 0; m_err = 1'b0;
        i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0; d_kind = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (i_act) begin
                if (i_done) i_act = 1'b0;
                else if ($urandom_range(19) == 0) i_act = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                i_act = 1'b1; bus.iaddr = $urandom;
            end
            if (d_act) begin
                if (d_done) d_act = 1'b0;
                else if ($urandom_range(29) == 0) d_act = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                d_act = 1'b1; d_kind = int'($urandom_range(2));
                bus.daddr = $urandom; bus.dstore = $urandom;
            end
            bus.iREN = i_act;
            bus.dREN = d_act && (d_kind != 1);
            bus.dWEN = d_act && (d_kind != 0);
            r = int'($urandom_range(19));
            bus.ramstate = (r < 8) ? S_ACCESS : (r < 13) ? S_BUSY : (r < 18) ? S_FREE : S_ERROR;
            bus.ramload  = $urandom;
            #1;

            e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
            e_addr = 32'd0; e_store = 32'd0; active = 1'b0;
            if (m_owner != 0) begin
                active = (m_owner == 1) ? bus.iREN : (m_owner == 2) ? bus.dREN : bus.dWEN;
                if (active) begin
                    e_ren  = (m_owner != 3);
                    e_wen  = (m_owner == 3);
                    e_addr = (m_owner == 1) ? bus.iaddr : bus.daddr;
                    if (m_owner == 3) e_store = bus.dstore;
                    if (bus.ramstate == S_ACCESS) begin
                        if (m_owner == 1) e_iw = 1'b0;
                        else e_dw = 1'b0;
                    end
                end
            end
            check("rnd_ramREN", 32'(bus.ramREN), 32'(e_ren));
            check("rnd_ramWEN", 32'(bus.ramWEN), 32'(e_wen));
            check("rnd_iwait", 32'(bus.iwait), 32'(e_iw));
            check("rnd_dwait", 32'(bus.dwait), 32'(e_dw));
            check("rnd_ramerr", 32'(bus.ramerr), 32'(m_err));
            check("rnd_iload", bus.iload, bus.ramload);
            check("rnd_dload", bus.dload, bus.ramload);
            if (e_ren || e_wen || m_owner == 0) begin
                check("rnd_ramaddr", bus.ramaddr, e_addr);
                check("rnd_ramstore", bus.ramstore, e_store);
            end
            i_done = !e_iw;
            d_done = !e_dw;

            // Advance the model by one clock
            if (m_owner == 0) begin
                if (bus.iREN && m_skips >= STARVE) begin
                    m_owner = 1; m_skips = 0;
                end else if (bus.dWEN || bus.dREN) begin
                    m_owner = bus.dWEN ? 3 : 2;
                    m_skips = bus.iREN ? ((m_skips + 1 > STARVE) ? STARVE : m_skips + 1) : 0;
                end else if (bus.iREN) begin
                    m_owner = 1; m_skips = 0;
                end
            end else if (!active || bus.ramstate == S_ACCESS) begin
                m_owner = 0;
            end else if (bus.ramstate == S_ERROR) begin
                m_err = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
